// File: rtl/yuv_seq_pkg.sv
// Shared types for the yuv_filter stage sequencer: FSM state encoding and stage index.
package yuv_seq_pkg;

  localparam int NUM_STAGES_DEF = 3;
  localparam int STAGE_IDX_W    = $clog2(NUM_STAGES_DEF);

  typedef logic [STAGE_IDX_W-1:0] stage_idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/yuv_seq_stage_counter.sv
// Saturating per-stage latency counter; clear has priority over enable.
module yuv_seq_stage_counter
  import yuv_seq_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_r;

  // Count while enabled, stick at all-ones until the next clear
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/yuv_filter_stage_seq.sv
// ap_ctrl_hs sequencer running RGB2YUV, YUV_SCALE, YUV2RGB strictly in order.
// Optional per-stage latency profiling is enabled with `define YUV_SEQ_PROFILE_EN.
module yuv_filter_stage_seq
  import yuv_seq_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int CNT_W      = 32
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic                          ap_start,
  output logic                          ap_done,
  output logic                          ap_ready,
  output logic                          ap_idle,
  output logic [NUM_STAGES-1:0]         grp_ap_start,
  input  logic [NUM_STAGES-1:0]         grp_ap_ready,
  input  logic [NUM_STAGES-1:0]         grp_ap_done,
  output logic [$clog2(NUM_STAGES)-1:0] cur_stage,
  output logic                          seq_err,
  output logic [NUM_STAGES*CNT_W-1:0]   stage_cycles
);

  localparam int                    IDX_W    = $clog2(NUM_STAGES);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] ONE_HOT0 = {{(NUM_STAGES-1){1'b0}}, 1'b1};

  seq_state_e            state_r;
  logic [IDX_W-1:0]      idx_r;
  logic [NUM_STAGES-1:0] start_r;
  logic                  done_r;
  logic                  idle_r;
  logic [IDX_W-1:0]      stage_r;
  logic                  err_r;

  logic                  accept_s;
  logic                  complete_s;
  logic                  advance_s;
  logic                  stray_s;
  logic [NUM_STAGES-1:0] own_mask_s;
  logic [NUM_STAGES-1:0] launch_mask_s;

  // Decode handshake events; a done seen in LAUNCH doubles as the missing ready
  always_comb begin
    accept_s = (state_r == IDLE) && ap_start;
    if ((state_r == LAUNCH) || (state_r == WAIT)) begin
      complete_s = grp_ap_done[idx_r];
    end else begin
      complete_s = 1'b0;
    end
    advance_s = complete_s && (idx_r != LAST_IDX);
    if (state_r == IDLE) begin
      own_mask_s = {NUM_STAGES{1'b0}};
    end else begin
      own_mask_s = ONE_HOT0 << idx_r;
    end
    stray_s = |((grp_ap_ready | grp_ap_done) & ~own_mask_s);
    if (accept_s) begin
      launch_mask_s = ONE_HOT0;
    end else if (advance_s) begin
      launch_mask_s = ONE_HOT0 << (idx_r + IDX_W'(1));
    end else begin
      launch_mask_s = {NUM_STAGES{1'b0}};
    end
  end

  // Sequencer FSM with all handshake outputs registered
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_r <= IDLE;
      idx_r   <= {IDX_W{1'b0}};
      start_r <= {NUM_STAGES{1'b0}};
      done_r  <= 1'b0;
      idle_r  <= 1'b1;
      stage_r <= {IDX_W{1'b0}};
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r <= LAUNCH;
            idx_r   <= {IDX_W{1'b0}};
            start_r <= launch_mask_s;
            idle_r  <= 1'b0;
            stage_r <= {IDX_W{1'b0}};
          end
        end
        LAUNCH, WAIT: begin
          if (advance_s) begin
            state_r <= LAUNCH;
            idx_r   <= idx_r + IDX_W'(1);
            stage_r <= idx_r + IDX_W'(1);
            start_r <= launch_mask_s;
          end else if (complete_s) begin
            state_r <= DONE;
            start_r <= {NUM_STAGES{1'b0}};
            done_r  <= 1'b1;
          end else if ((state_r == LAUNCH) && grp_ap_ready[idx_r]) begin
            state_r <= WAIT;
            start_r <= {NUM_STAGES{1'b0}};
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          idle_r  <= 1'b1;
          stage_r <= {IDX_W{1'b0}};
        end
        default: begin
          state_r <= IDLE;
          start_r <= {NUM_STAGES{1'b0}};
          done_r  <= 1'b0;
          idle_r  <= 1'b1;
          stage_r <= {IDX_W{1'b0}};
        end
      endcase
      // A stray pulse in the accept cycle still flags, so set beats clear
      err_r <= stray_s | (err_r & ~accept_s);
    end
  end

  assign ap_done      = done_r;
  assign ap_ready     = done_r;
  assign ap_idle      = idle_r;
  assign grp_ap_start = start_r;
  assign cur_stage    = stage_r;
  assign seq_err      = err_r;

`ifdef YUV_SEQ_PROFILE_EN
  logic [NUM_STAGES-1:0] cnt_en_s;

  // Only the active stage's counter runs, through LAUNCH and WAIT inclusive
  always_comb begin
    if ((state_r == LAUNCH) || (state_r == WAIT)) begin
      cnt_en_s = ONE_HOT0 << idx_r;
    end else begin
      cnt_en_s = {NUM_STAGES{1'b0}};
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_prof
    yuv_seq_stage_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .clr      (launch_mask_s[k]),
      .en       (cnt_en_s[k]),
      .cnt      (stage_cycles[k*CNT_W +: CNT_W])
    );
  end
`else
  assign stage_cycles = {(NUM_STAGES*CNT_W){1'b0}};
`endif

endmodule

// File: tb/tb_yuv_filter_stage_seq.sv
// Self-checking bench for yuv_filter_stage_seq: directed and randomized child timing
// checked cycle by cycle against a timeline model of the sequencing rules.
module tb_yuv_filter_stage_seq;

  localparam int NS = 3;
  localparam int CW = 4;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          ap_start = 1'b0;
  logic          ap_done;
  logic          ap_ready;
  logic          ap_idle;
  logic [NS-1:0] grp_ap_start;
  logic [NS-1:0] grp_ap_ready = '0;
  logic [NS-1:0] grp_ap_done = '0;
  logic [1:0]    cur_stage;
  logic          seq_err;
  logic [NS*CW-1:0] stage_cycles;

  yuv_filter_stage_seq #(.NUM_STAGES(NS), .CNT_W(CW)) dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .ap_start     (ap_start),
    .ap_done      (ap_done),
    .ap_ready     (ap_ready),
    .ap_idle      (ap_idle),
    .grp_ap_start (grp_ap_start),
    .grp_ap_ready (grp_ap_ready),
    .grp_ap_done  (grp_ap_done),
    .cur_stage    (cur_stage),
    .seq_err      (seq_err),
    .stage_cycles (stage_cycles)
  );

  always #5 ap_clk = ~ap_clk;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rd[NS];
  int   dd[NS];
  int   stray_k = -1;
  int   stray_bit = 0;
  int   stray_j = 0;
  int   stray_rdy = 0;
  int   abort_k = -1;
  logic err_exp = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
    cyc++;
  endtask

  // Expected latency registers: (done offset + 1) per stage, saturating at 2^CW-1
  function automatic logic [63:0] prof_exp();
    logic [63:0] v;
    v = 64'd0;
`ifdef YUV_SEQ_PROFILE_EN
    for (int k = 0; k < NS; k++) begin
      v = v | (64'(((dd[k] + 1) > 15) ? 15 : (dd[k] + 1)) << (k * CW));
    end
`endif
    return v;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_idle"}, 64'(ap_idle), 64'd1);
    chk({tag, "_start"}, 64'(grp_ap_start), 64'd0);
    chk({tag, "_done"}, 64'(ap_done), 64'd0);
    chk({tag, "_cur"}, 64'(cur_stage), 64'd0);
  endtask

  // One full block run; stage k sees ready at offset rd[k] and done at dd[k] after its start rises
  task automatic run();
    int          c0;
    int          re;
    int          total;
    logic [NS-1:0] rdy;
    logic [NS-1:0] dn;
    c0 = cyc;
    total = 1;
    ap_start = 1'b1;
    step();
    err_exp = 1'b0;
    for (int k = 0; k < NS; k++) begin
      re = (rd[k] < dd[k]) ? rd[k] : dd[k];
      total += dd[k] + 1;
      for (int j = 0; j <= dd[k]; j++) begin
        if (k == abort_k && j == re + 1) begin
          grp_ap_ready = '0;
          grp_ap_done = '0;
          ap_rst_n = 1'b0;
          step();
          ap_rst_n = 1'b1;
          ap_start = 1'b0;
          check_idle("rst_mid");
          chk("rst_mid_err", 64'(seq_err), 64'd0);
          chk("rst_mid_prof", 64'(stage_cycles), 64'd0);
          err_exp = 1'b0;
          abort_k = -1;
          return;
        end
        rdy = '0;
        dn = '0;
        if (j == rd[k]) rdy[k] = 1'b1;
        if (j == dd[k]) dn[k] = 1'b1;
        if (k == stray_k && j == stray_j) begin
          if (stray_rdy != 0) rdy[stray_bit] = 1'b1;
          else dn[stray_bit] = 1'b1;
        end
        grp_ap_ready = rdy;
        grp_ap_done = dn;
        ap_start = 1'($urandom_range(0, 1));
        chk("grp_start", 64'(grp_ap_start), (j <= re) ? (64'd1 << k) : 64'd0);
        chk("cur_stage", 64'(cur_stage), 64'(k));
        chk("busy_idle", 64'(ap_idle), 64'd0);
        chk("busy_done", 64'({ap_done, ap_ready}), 64'd0);
        chk("seq_err", 64'(seq_err), 64'(err_exp));
        step();
        if (k == stray_k && j == stray_j) err_exp = 1'b1;
      end
    end
    grp_ap_ready = '0;
    grp_ap_done = '0;
    ap_start = 1'b0;
    chk("fin_done_ready", 64'({ap_done, ap_ready}), 64'd3);
    chk("fin_start", 64'(grp_ap_start), 64'd0);
    chk("fin_cur", 64'(cur_stage), 64'(NS - 1));
    chk("fin_idle", 64'(ap_idle), 64'd0);
    chk("fin_err", 64'(seq_err), 64'(err_exp));
    chk("fin_cycle", 64'(cyc - c0), 64'(total));
    chk("fin_prof", 64'(stage_cycles), prof_exp());
    step();
    check_idle("post");
    chk("post_ready", 64'(ap_ready), 64'd0);
    chk("post_err", 64'(seq_err), 64'(err_exp));
    stray_k = -1;
  endtask

  task automatic set_times(input int r0, input int d0, input int r1, input int d1,
                           input int r2, input int d2);
    rd[0] = r0; dd[0] = d0;
    rd[1] = r1; dd[1] = d1;
    rd[2] = r2; dd[2] = d2;
  endtask

  initial begin
    // Reset, then ten quiet cycles
    repeat (3) step();
    ap_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check_idle("reset");
      chk("reset_err", 64'(seq_err), 64'd0);
      chk("reset_prof", 64'(stage_cycles), 64'd0);
      step();
    end

    // Nominal: ready 1 cycle, done 5 cycles after each start; ap_done at cycle 19
    set_times(1, 5, 1, 5, 1, 5);
    run();

    // Stage 1 raises ready and done together
    set_times(1, 3, 2, 2, 0, 2);
    run();

    // Stray done[2] while stage 0 runs; sticky until next accepted start
    set_times(1, 5, 1, 4, 2, 3);
    stray_k = 0; stray_bit = 2; stray_j = 2; stray_rdy = 0;
    run();
    chk("stray_sticky", 64'(seq_err), 64'd1);
    set_times(0, 2, 1, 1, 1, 3);
    run();

    // Stray ready while idle
    grp_ap_ready = 3'b010;
    step();
    grp_ap_ready = '0;
    chk("idle_stray", 64'(seq_err), 64'd1);
    step();
    chk("idle_stray_hold", 64'(seq_err), 64'd1);
    set_times(2, 4, 1, 3, 0, 0);
    run();

    // Reset while waiting on stage 1, then a clean run
    set_times(1, 3, 1, 6, 1, 2);
    abort_k = 1;
    run();
    set_times(1, 3, 1, 6, 1, 2);
    run();

    // Done with no prior ready on stage 0
    set_times(9, 3, 1, 2, 5, 1);
    run();

    // Profiling latencies 4/7/2, then overwrite with a saturating 20-cycle stage
    set_times(1, 4, 2, 7, 1, 2);
    run();
    set_times(3, 1, 1, 20, 0, 5);
    run();

    // Randomized child timing, stray pulses and idle gaps
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < NS; k++) begin
        dd[k] = int'($urandom_range(0, 12));
        rd[k] = int'($urandom_range(0, dd[k] + 2));
      end
      if ($urandom_range(0, 2) == 0) begin
        stray_k = int'($urandom_range(0, NS - 1));
        stray_bit = (stray_k + int'($urandom_range(1, NS - 1))) % NS;
        stray_j = int'($urandom_range(0, dd[stray_k]));
        stray_rdy = int'($urandom_range(0, 1));
      end else begin
        stray_k = -1;
      end
      run();
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        step();
        check_idle("gap");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
